// File: rtl/filter_frame_ctrl.sv
// filter_frame_ctrl
// ------------------------------------------------------------------------
// Frame-synchronous controller for the 3x3 sharpening datapath.
// - Follows the video timing (dv/hs/vs) and produces pix_count and
//   line_count for the filter.
// - Owns the filter bypass control.
// - Accepts configuration (bypass, expected width/height) at any time, but
//   applies it only on a vertical-sync rising edge. No frame is ever
//   processed with mixed settings.
// - Measures the geometry of every complete frame and pulses frame_err
//   when it does not match the active width/height.
// - Keeps a saturating count of erroneous frames.
//
// Optional build macro: FILTER_CTRL_AUTO_BYPASS_EN
//   When defined, a frame that ends with frame_err forces bypass=1 for the
//   next frame. The normal config value returns at the following vs_rise,
//   unless that frame errs as well.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous, active-high reset
//   dv_in        in   pixel valid
//   hs_in        in   horizontal sync (high during line blank)
//   vs_in        in   vertical sync (high during frame blank)
//   cfg_valid    in   config write request
//   cfg_ready    out  controller can accept config
//   cfg_bypass   in   requested bypass
//   cfg_width    in   requested expected pixels/line
//   cfg_height   in   requested expected lines/frame
//   bypass       out  active bypass to filter
//   pix_count    out  valid pixels so far in current line
//   line_count   out  completed lines in current frame
//   frame_done   out  one-cycle pulse at end of frame
//   meas_width   out  pixel count of first line of last frame
//   meas_height  out  line count of last frame
//   frame_err    out  one-cycle pulse with frame_done on geometry mismatch
//   err_cnt      out  saturating count of erroneous frames
//   state        out  FSM state (0 SYNC, 1 VBLANK, 2 ACTIVE)
// ------------------------------------------------------------------------
module filter_frame_ctrl #(
   parameter logic BYPASS_RST = 1'b1,
   parameter int   DEF_WIDTH  = 640,
   parameter int   DEF_HEIGHT = 480,
   parameter int   ERRCNT_W   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dv_in,
   input  logic                hs_in,
   input  logic                vs_in,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic                cfg_bypass,
   input  logic [15:0]         cfg_width,
   input  logic [15:0]         cfg_height,
   output logic                bypass,
   output logic [15:0]         pix_count,
   output logic [15:0]         line_count,
   output logic                frame_done,
   output logic [15:0]         meas_width,
   output logic [15:0]         meas_height,
   output logic                frame_err,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic [1:0]          state
);

   localparam logic [1:0] SYNC   = 2'd0;
   localparam logic [1:0] VBLANK = 2'd1;
   localparam logic [1:0] ACTIVE = 2'd2;

   localparam logic [15:0]         CNT_MAX = 16'hFFFF;
   localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};

   // Input edge detection
   logic vs_d;
   logic hs_d;
   logic vs_rise;
   logic vs_fall;
   logic hs_rise;

   // FSM and counters
   logic [1:0]  state_r;
   logic [15:0] pix_r;
   logic [15:0] line_r;
   logic [15:0] width_smp;
   logic        line_err;

   // Active and shadow configuration
   logic        act_byp;
   logic [15:0] act_w;
   logic [15:0] act_h;
   logic        sh_byp;
   logic [15:0] sh_w;
   logic [15:0] sh_h;
   logic        pending;
   logic        bypass_r;

   // Registered outputs
   logic                done_r;
   logic                err_r;
   logic [15:0]         meas_w_r;
   logic [15:0]         meas_h_r;
   logic [ERRCNT_W-1:0] err_cnt_r;

   // Combinational helpers
   logic        line_has;
   logic [15:0] pix_next;
   logic [15:0] line_inc;
   logic        in_active;
   logic        close_line;
   logic        first_line;
   logic        line_bad;
   logic        eof;
   logic [15:0] eof_width;
   logic [15:0] eof_lines;
   logic        eof_err;
   logic        byp_cfg_next;
   logic        cfg_accept;

   assign vs_rise =  vs_in & ~vs_d;
   assign vs_fall = ~vs_in &  vs_d;
   assign hs_rise =  hs_in & ~hs_d;

   // Config port: a transfer happens on any cycle where cfg_valid and
   // cfg_ready are both high. cfg_ready is low while a captured config is
   // waiting for its vs_rise. The requester must hold cfg_valid and the
   // fields stable until it sees the transfer.
   assign cfg_ready  = ~pending;
   assign cfg_accept = cfg_valid & ~pending;

   always_comb begin
      line_has   = (pix_r != 16'd0) | dv_in;
      // Final pixel count of the current line, including a pixel in this cycle.
      pix_next   = (dv_in && (pix_r != CNT_MAX)) ? pix_r + 16'd1 : pix_r;
      line_inc   = (line_r != CNT_MAX) ? line_r + 16'd1 : line_r;
      in_active  = (state_r == ACTIVE);
      // A vs_rise without a preceding hs_rise also closes a non-empty line.
      close_line = in_active & (hs_rise | vs_rise) & line_has;
      first_line = (line_r == 16'd0);
      line_bad   = close_line & (pix_next != act_w);
      eof        = in_active & vs_rise;
      eof_width  = (close_line && first_line) ? pix_next : width_smp;
      eof_lines  = close_line ? line_inc : line_r;
      eof_err    = line_err | line_bad | (eof_lines != act_h);
      byp_cfg_next = pending ? sh_byp : act_byp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d      <= 1'b0;
         hs_d      <= 1'b0;
         state_r   <= SYNC;
         pix_r     <= 16'd0;
         line_r    <= 16'd0;
         width_smp <= 16'd0;
         line_err  <= 1'b0;
         act_byp   <= BYPASS_RST;
         act_w     <= 16'(DEF_WIDTH);
         act_h     <= 16'(DEF_HEIGHT);
         sh_byp    <= BYPASS_RST;
         sh_w      <= 16'(DEF_WIDTH);
         sh_h      <= 16'(DEF_HEIGHT);
         pending   <= 1'b0;
         bypass_r  <= BYPASS_RST;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
         meas_w_r  <= 16'd0;
         meas_h_r  <= 16'd0;
         err_cnt_r <= '0;
      end else begin
         vs_d   <= vs_in;
         hs_d   <= hs_in;
         done_r <= 1'b0;
         err_r  <= 1'b0;

         case (state_r)
            SYNC: begin
               // Wait for a frame boundary; a partial frame is never measured.
               pix_r  <= 16'd0;
               line_r <= 16'd0;
               if (vs_rise) state_r <= VBLANK;
            end
            VBLANK: begin
               if (vs_fall) begin
                  state_r   <= ACTIVE;
                  pix_r     <= 16'd0;
                  line_r    <= 16'd0;
                  width_smp <= 16'd0;
                  line_err  <= 1'b0;
               end
            end
            ACTIVE: begin
               if (close_line) begin
                  pix_r  <= 16'd0;
                  line_r <= line_inc;
                  if (first_line) width_smp <= pix_next;
                  if (line_bad)   line_err  <= 1'b1;
               end else begin
                  pix_r <= pix_next;
               end
               if (vs_rise) begin
                  state_r  <= VBLANK;
                  meas_w_r <= eof_width;
                  meas_h_r <= eof_lines;
                  done_r   <= 1'b1;
                  err_r    <= eof_err;
                  line_err <= 1'b0;
                  if (eof_err && (err_cnt_r != ERR_MAX))
                     err_cnt_r <= err_cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= SYNC;
               pix_r   <= 16'd0;
               line_r  <= 16'd0;
            end
         endcase

         // Config is applied on every vs_rise, whatever the state. A write
         // accepted in the same cycle only sets pending, so it waits for
         // the next boundary.
         if (vs_rise) begin
`ifdef FILTER_CTRL_AUTO_BYPASS_EN
            bypass_r <= byp_cfg_next | (eof & eof_err);
`else
            bypass_r <= byp_cfg_next;
`endif
            if (pending) begin
               act_byp <= sh_byp;
               act_w   <= sh_w;
               act_h   <= sh_h;
               pending <= 1'b0;
            end
         end

         if (cfg_accept) begin
            sh_byp  <= cfg_bypass;
            sh_w    <= cfg_width;
            sh_h    <= cfg_height;
            pending <= 1'b1;
         end
      end
   end

   assign bypass      = bypass_r;
   assign pix_count   = pix_r;
   assign line_count  = line_r;
   assign frame_done  = done_r;
   assign meas_width  = meas_w_r;
   assign meas_height = meas_h_r;
   assign frame_err   = err_r;
   assign err_cnt     = err_cnt_r;
   assign state       = state_r;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed testbench for filter_frame_ctrl.
// It uses reduced default geometry (16x8) so that each frame stays short.
// Inputs change on the falling clock edge and outputs are sampled on the
// falling edge as well.
module tb_filter_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        dv_in;
   logic        hs_in;
   logic        vs_in;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_bypass;
   logic [15:0] cfg_width;
   logic [15:0] cfg_height;
   logic        bypass;
   logic [15:0] pix_count;
   logic [15:0] line_count;
   logic        frame_done;
   logic [15:0] meas_width;
   logic [15:0] meas_height;
   logic        frame_err;
   logic [7:0]  err_cnt;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;
   int done_seen = 0;
   int err_seen  = 0;
   int d0;
   int e0;
   logic exp_auto_byp;

   filter_frame_ctrl #(
      .BYPASS_RST (1'b1),
      .DEF_WIDTH  (16),
      .DEF_HEIGHT (8),
      .ERRCNT_W   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dv_in       (dv_in),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_bypass  (cfg_bypass),
      .cfg_width   (cfg_width),
      .cfg_height  (cfg_height),
      .bypass      (bypass),
      .pix_count   (pix_count),
      .line_count  (line_count),
      .frame_done  (frame_done),
      .meas_width  (meas_width),
      .meas_height (meas_height),
      .frame_err   (frame_err),
      .err_cnt     (err_cnt),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Frame-end monitor: counts pulses; frame_err must coincide with frame_done.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_done) done_seen++;
         if (frame_err) begin
            err_seen++;
            check("err_with_done", {31'd0, frame_done}, 32'd1);
         end
      end
   end

   task automatic pix(input int n);
      for (int i = 0; i < n; i++) begin
         dv_in = 1'b1;
         @(negedge clk);
      end
      dv_in = 1'b0;
   endtask

   task automatic hs_end();
      hs_in = 1'b1;
      repeat (2) @(negedge clk);
      hs_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic lines(input int w, input int h, input int badl, input int badw);
      for (int i = 0; i < h; i++) begin
         pix((i == badl) ? badw : w);
         hs_end();
      end
   endtask

   task automatic vs_pulse();
      vs_in = 1'b1;
      repeat (4) @(negedge clk);
      vs_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic cfg_write(input logic b, input logic [15:0] w, input logic [15:0] h);
      cfg_valid  = 1'b1;
      cfg_bypass = b;
      cfg_width  = w;
      cfg_height = h;
      @(negedge clk);
      cfg_valid  = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_state"},  {30'd0, state}, 32'd0);
      check({tag, "_bypass"}, {31'd0, bypass}, 32'd1);
      check({tag, "_ready"},  {31'd0, cfg_ready}, 32'd1);
      check({tag, "_pix"},    {16'd0, pix_count}, 32'd0);
      check({tag, "_line"},   {16'd0, line_count}, 32'd0);
      check({tag, "_mw"},     {16'd0, meas_width}, 32'd0);
      check({tag, "_mh"},     {16'd0, meas_height}, 32'd0);
      check({tag, "_errcnt"}, {24'd0, err_cnt}, 32'd0);
      check({tag, "_done"},   {31'd0, frame_done}, 32'd0);
      check({tag, "_ferr"},   {31'd0, frame_err}, 32'd0);
   endtask

   initial begin
`ifdef FILTER_CTRL_AUTO_BYPASS_EN
      exp_auto_byp = 1'b1;
`else
      exp_auto_byp = 1'b0;
`endif
      rst = 1'b1; dv_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
      cfg_valid = 1'b0; cfg_bypass = 1'b0; cfg_width = '0; cfg_height = '0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst = 1'b0;
      @(negedge clk);

      // Default geometry; the first frame_done follows the second vs_rise.
      vs_pulse();
      check("active_state", {30'd0, state}, 32'd2);
      lines(16, 8, -1, 0);
      check("line_count8", {16'd0, line_count}, 32'd8);
      check("no_done_yet", done_seen, 0);
      vs_pulse();
      check("done1", done_seen, 1);
      check("mw1", {16'd0, meas_width}, 32'd16);
      check("mh1", {16'd0, meas_height}, 32'd8);
      // The zero-pixel line at the start of this frame must be ignored.
      hs_end();
      pix(5);
      check("pix5", {16'd0, pix_count}, 32'd5);
      pix(11);
      hs_end();
      lines(16, 7, -1, 0);
      vs_pulse();
      check("done2", done_seen, 2);
      check("mw2_zero_line", {16'd0, meas_width}, 32'd16);
      check("mh2_zero_line", {16'd0, meas_height}, 32'd8);
      lines(16, 8, -1, 0);
      vs_pulse();
      check("done3", done_seen, 3);
      check("no_err3", err_seen, 0);
      check("errcnt3", {24'd0, err_cnt}, 32'd0);
      check("bypass3", {31'd0, bypass}, 32'd1);

      // A mid-frame config write is applied at the next vs_rise.
      lines(16, 3, -1, 0);
      cfg_write(1'b0, 16'd8, 16'd4);
      check("cfg_busy", {31'd0, cfg_ready}, 32'd0);
      check("byp_hold_a", {31'd0, bypass}, 32'd1);
      lines(16, 5, -1, 0);
      check("byp_hold_b", {31'd0, bypass}, 32'd1);
      vs_pulse();
      check("byp_applied", {31'd0, bypass}, 32'd0);
      check("cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
      check("no_err4", err_seen, 0);
      check("done4", done_seen, 4);
      lines(8, 4, -1, 0);
      vs_pulse();
      check("no_err_8x4", err_seen, 0);
      check("mw_8x4", {16'd0, meas_width}, 32'd8);
      check("mh_8x4", {16'd0, meas_height}, 32'd4);

      // Config accepted in the same cycle as vs_rise waits one boundary.
      lines(8, 4, -1, 0);
      vs_in = 1'b1;
      cfg_write(1'b1, 16'd8, 16'd4);
      check("cfg_vs_busy", {31'd0, cfg_ready}, 32'd0);
      check("cfg_vs_byp0", {31'd0, bypass}, 32'd0);
      repeat (3) @(negedge clk);
      vs_in = 1'b0;
      @(negedge clk);
      check("cfg_vs_byp1", {31'd0, bypass}, 32'd0);
      lines(8, 4, -1, 0);
      vs_pulse();
      check("cfg_vs_applied", {31'd0, bypass}, 32'd1);
      check("cfg_vs_ready", {31'd0, cfg_ready}, 32'd1);
      check("no_err5", err_seen, 0);

      // A short line raises frame_err; the first line still measures 8.
      cfg_write(1'b0, 16'd8, 16'd4);
      lines(8, 4, 2, 7);
      vs_pulse();
      check("bad_err_seen", err_seen, 1);
      check("bad_errcnt", {24'd0, err_cnt}, 32'd1);
      check("bad_mw", {16'd0, meas_width}, 32'd8);
      check("bad_mh", {16'd0, meas_height}, 32'd4);
      check("bad_bypass", {31'd0, bypass}, {31'd0, exp_auto_byp});
      lines(8, 4, -1, 0);
      vs_pulse();
      check("after_bad_bypass", {31'd0, bypass}, 32'd0);
      check("after_bad_errcnt", {24'd0, err_cnt}, 32'd1);

      // Height mismatch every frame drives err_cnt into saturation.
      repeat (253) begin
         lines(8, 1, -1, 0);
         vs_pulse();
      end
      check("errcnt254", {24'd0, err_cnt}, 32'd254);
      repeat (7) begin
         lines(8, 1, -1, 0);
         vs_pulse();
      end
      check("errcnt_sat", {24'd0, err_cnt}, 32'd255);
      check("err_pulses", err_seen, 261);

      // Reset mid-line with a pending config discards that config.
      lines(8, 2, -1, 0);
      cfg_write(1'b0, 16'd5, 16'd3);
      dv_in = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      dv_in = 1'b0;
      @(negedge clk);
      check_reset("midrst");
      rst = 1'b0;
      @(negedge clk);
      vs_pulse();
      lines(16, 8, -1, 0);
      d0 = done_seen;
      e0 = err_seen;
      vs_pulse();
      check("post_rst_done", done_seen, d0 + 1);
      check("post_rst_no_err", err_seen, e0);
      check("post_rst_mw", {16'd0, meas_width}, 32'd16);
      check("post_rst_mh", {16'd0, meas_height}, 32'd8);
      check("post_rst_bypass", {31'd0, bypass}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
